// File: rtl/des_sbox_sequencer.sv
// des_sbox_sequencer: runs the eight DES S-box lookups of one round through one shared
// lookup port, one box per clock, and packs the eight nibbles into the 32-bit result.
module des_sbox_sequencer #(
    parameter int NUM_BOXES = 8  // only 8 is meaningful for DES; sbox_sel is sized for it
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6*NUM_BOXES-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   sbox_en,
    output logic [2:0]             sbox_sel,
    output logic [5:0]             sbox_in,
    input  logic [3:0]             sbox_out,
    output logic [4*NUM_BOXES-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CHUNK_W = 6;
    localparam int NIB_W   = 4;
    localparam int IN_W    = CHUNK_W * NUM_BOXES;
    localparam int OUT_W   = NIB_W * NUM_BOXES;
    localparam logic [2:0] LAST_IDX = 3'(NUM_BOXES - 1);

    typedef enum logic [1:0] {
        st_idle,
        st_lookup,
        st_done
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         idx;
    logic [2:0]         idx_nxt;
    logic [IN_W-1:0]    in_reg;
    logic [OUT_W-1:0]   result;
    logic [CHUNK_W-1:0] chunk;
    logic               accept;

    assign accept   = in_valid & in_ready;
    assign out_data = result;

    // Box 0 (S1) owns the most significant chunk of the input word.
    always_comb begin
        chunk = '0;
        for (int b = 0; b < NUM_BOXES; b++) begin
            if (idx == 3'(b)) begin
                chunk = in_reg[IN_W-CHUNK_W*(b+1) +: CHUNK_W];
            end
        end
    end

    // NOTE: every registered signal uses <= so all flops sample pre-edge values together.
    // NOTE: in_reg and result carry a reset only because out_data must read zero after
    // reset and a reset must discard any partial result; plain datapath regs need none.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= st_idle;
            idx    <= '0;
            in_reg <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                in_reg <= in_data;
            end
            if (state == st_lookup) begin
                for (int b = 0; b < NUM_BOXES; b++) begin
                    if (idx == 3'(b)) begin
                        result[OUT_W-NIB_W*(b+1) +: NIB_W] <= sbox_out;
                    end
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sbox_en   = 1'b0;
        sbox_sel  = '0;
        sbox_in   = '0;
        case (state)
            st_idle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = st_lookup;
                    idx_nxt   = '0;
                end
            end
            st_lookup: begin
                sbox_en  = 1'b1;
                sbox_sel = idx;
                sbox_in  = chunk;
                if (idx == LAST_IDX) begin
                    state_nxt = st_done;
                end else begin
                    idx_nxt = idx + 3'd1;
                end
            end
            st_done: begin
                out_valid = 1'b1;
                // A new word may enter in the same cycle the held result is taken.
                in_ready  = out_ready;
                if (out_ready) begin
                    idx_nxt   = '0;
                    state_nxt = in_valid ? st_lookup : st_idle;
                end
            end
            default: begin
                state_nxt = st_idle;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule
